// File: rtl/alu_pkg.sv
// Shared constants, ALU control encodings and immediate extension.
package alu_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  // Bit 3 is a don't-care for all but the shifts; encoded as 0 here.
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  function automatic logic [DW-1:0] ext_imm(
    input logic [15:0] imm,
    input logic        sext
  );
    logic [DW-17:0] hi;
    hi = sext ? {(DW-16){imm[15]}} : '0;
    return {hi, imm};
  endfunction

endpackage

// File: rtl/regfile32.sv
// General register file: two async reads, one write, r0 hardwired zero.
// Write-through bypass enabled by ALU_OPF_BYPASS_EN.
module regfile32 #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we && wn != '0) begin
      mem[wn] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : mem[ra2];
`ifdef ALU_OPF_BYPASS_EN
    if (we && ra1 != '0 && wn == ra1)
      rd1 = wd;
    if (we && ra2 != '0 && wn == ra2)
      rd2 = wd;
`endif
  end

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand fetch: register read, operand muxing, one-slot output register.
// Optional write-through bypass: ALU_OPF_BYPASS_EN.
module alu_operand_fetch #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [15:0]   imm,
  input  logic [4:0]    sa,
  input  logic [3:0]    aluc_in,
  input  logic          sel_a_sa,
  input  logic          sel_b_imm,
  input  logic          sext,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [3:0]    aluc,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rn,
  input  logic [DW-1:0] wb_d
);

  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [DW-1:0] ext;
  logic [DW-1:0] a_nxt;
  logic [DW-1:0] b_nxt;
  logic          acc;

  regfile32 #(
    .DW  (DW),
    .AW  (AW),
    .NREG(NREG)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .we (wb_we),
    .wn (wb_rn),
    .wd (wb_d),
    .ra1(rs),
    .rd1(rd_a),
    .ra2(rt),
    .rd2(rd_b)
  );

  always_comb begin
    ext = '0;
    ext[15:0] = imm;
    if (sext)
      ext = {{(DW-16){imm[15]}}, imm};
  end

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign a_nxt    = sel_a_sa ? {{(DW-5){1'b0}}, sa} : rd_a;
  assign b_nxt    = sel_b_imm ? ext : rd_b;

  // Held operands are snapshots; later writebacks never reach them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      aluc      <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      a         <= a_nxt;
      b         <= b_nxt;
      aluc      <= aluc_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
Operand-fetch stage directly upstream of the 32-bit ALU. Holds the 32x32 general register file and selects the ALU `a` and `b` operands from registers, zero- or sign-extended immediate, or shift amount. Presents both operands through one registered valid/ready pipeline slot that feeds the ALU.
Writeback from the downstream stage enters through a single write port.

Parameters:
DW, 32, data width of registers and operands
AW, 5, register address width
NREG, 32, number of registers; r0 reads as zero

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  decoded instruction fields valid
in_ready  out  1  stage can accept the fields this cycle
rs  in  AW  source register for `a`
rt  in  AW  source register for `b`
imm  in  16  instruction immediate
sa  in  5  shift amount field
aluc_in  in  4  ALU control, carried alongside the operands
sel_a_sa  in  1  1: a = {27'b0, sa}; 0: a = rf[rs]
sel_b_imm  in  1  1: b = extended imm; 0: b = rf[rt]
sext  in  1  1: sign-extend imm; 0: zero-extend imm
out_valid  out  1  operand slot full
out_ready  in  1  ALU side consumes the slot this cycle
a  out  DW  ALU operand a
b  out  DW  ALU operand b
aluc  out  4  registered ALU control
wb_we  in  1  writeback enable
wb_rn  in  AW  writeback register number
wb_d  in  DW  writeback data

Behaviour:
- Reset:
  - out_valid=0, a=0, b=0, aluc=0.
  - All NREG registers cleared to 0 on the same edge.
  - Reset wins over any simultaneous handshake or writeback.
- Handshake rule: in_ready = !out_valid || out_ready, combinational.
- Accept occurs on (in_valid && in_ready). Latency is 1 cycle: the accepted fields appear on a/b/aluc with out_valid=1 at the next edge.
- If there is no accept and out_ready=1, out_valid goes to 0.
- If out_valid=1 and out_ready=0, a/b/aluc hold stable. A writeback to a captured register does not alter the held operands.
- Operand a: sel_a_sa ? {27'b0, sa} : rd(rs).
- Operand b: sel_b_imm ? (sext ? {{16{imm[15]}}, imm} : {16'b0, imm}) : rd(rt).
- rd(n): returns 0 when n==0, otherwise rf[n] (subject to the bypass rule under Optional Feature).
- Writes:
  - rf[wb_rn] <= wb_d at the edge when wb_we && wb_rn!=0 && !rst.
  - A write to r0 is discarded.
  - Writes proceed regardless of in_valid/out_ready.
- Simultaneous accept and out_ready=1 is back-to-back throughput: out_valid stays 1 and the slot is replaced.
- A reset mid-stall drops the held operand; no output is produced for it.

Optional Feature:
- Macro: ALU_OPF_BYPASS_EN.
- Defined: a read of register n in the same cycle as wb_we && wb_rn==n && n!=0 returns wb_d (write-through).
- Undefined: such a read returns the old rf[n]; the new value is visible from the next cycle.

Decomposition:
- Package alu_pkg holds:
  - DW/AW constants.
  - ALUC encodings: 4'bx000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui, 0011 sll, 0111 srl, 1111 sra.
  - Immediate-extension helper function.
- Sub-module regfile32: storage, two combinational read ports, one write port, r0 forced zero, bypass under ALU_OPF_BYPASS_EN.
- The handshake register and operand muxing live in alu_operand_fetch.

Test Plan:
1. Reset, then read all rs/rt with sel bits 0 -> every a=b=0; out_valid=0 for the whole reset cycle.
2. Write r5=0x12345678, r6=0xFFFF0000, then issue rs=5, rt=6, aluc=0001 -> next cycle out_valid=1, a=0x12345678, b=0xFFFF0000, aluc=0001.
3. imm=0x8000 with sel_b_imm=1:
   - sext=1 -> b=0xFFFF8000.
   - sext=0 -> b=0x00008000.
   - sel_a_sa=1, sa=31 -> a=0x0000001F.
4. Write r0=0xDEADBEEF, then read rs=0 -> a=0.
5. Same-cycle wb_we to r7=0xA5A5A5A5 and read rs=7 (old value 0):
   - Bypass defined -> a=0xA5A5A5A5.
   - Undefined -> a=0; re-read the next cycle -> 0xA5A5A5A5.
6. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and a/b stable, even with a writeback to the captured rs. Then out_ready=1 -> new operands the following cycle. Assert rst mid-stall -> out_valid=0 on the next edge.
